mips_dbg_loader: RTL and testbench
==================================

# mips_dbg_loader

Single-clock debug/load responder for the 5-stage MIPS32 core. It accepts word commands from a host and uses them to:
- write and read back instruction/data memory,
- read the register file,
- release the core to run from PC 0.

It sits between an external host link and the core's memory write port, register-file read port and control (HALTED/PC/TAKEN_BRANCH init). It replaces hierarchical pokes and peeks with a real handshake interface.

## Interface
Parameters:
- AW, 10, memory word-address width (1024 words)
- DW, 32, data width

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  responder can accept a command
- cmd_op  in  2  0=WR_MEM, 1=RD_MEM, 2=RD_REG, 3=RUN
- cmd_addr  in  AW  word address; RD_REG uses bits [4:0]
- cmd_data  in  DW  write data (WR_MEM only)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_data  out  DW  read data; 0 for WR_MEM/RUN
- rsp_err  out  1  command rejected
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after mem_addr (registered read)
- reg_raddr  out  5  register-file read address
- reg_rdata  in  DW  register-file data, combinational from reg_raddr
- core_halted  in  1  core HALTED flag
- core_hold  out  1  freezes core fetch; 1 while loading
- core_start  out  1  one-cycle pulse: core clears HALTED and TAKEN_BRANCH, sets PC=0

## Operation
States: IDLE, WR, RD_A, RD_D, REG, START, RESP.

- IDLE: cmd_ready=1. On cmd_valid, latch op, addr and data, then branch:
  - op 0 -> WR
  - op 1 -> RD_A
  - op 2 -> REG
  - op 3 -> START
- Busy rule: if core_hold=0 and core_halted=0 (core running), ops 0–2 are rejected and go directly to RESP with rsp_err=1 and rsp_data=0. RUN while running is also rejected the same way.
- WR: mem_we=1, mem_addr=addr, mem_wdata=data, for exactly one cycle. Then RESP with rsp_data=0.
- RD_A: drive mem_addr=addr for one cycle.
- RD_D: capture mem_rdata into rsp_data. Then RESP.
- REG: reg_raddr=addr[4:0]; capture reg_rdata into rsp_data in the same cycle. Then RESP.
- START: core_start=1 and core_hold cleared in the same cycle. Then RESP with rsp_data=0.
- RESP: rsp_valid=1, holding rsp_data and rsp_err stable until rsp_ready. On the handshake -> IDLE.
- core_hold: set by reset and by the completion of any accepted WR. Cleared only by START. While core_halted=1 after a run, memory and register accesses are allowed without re-asserting hold.
- Addresses wrap modulo 2^AW. No range error exists. RD_REG ignores addr[AW-1:5].
- One command is outstanding at a time. No pipelining.

## Timing
- Reset values (synchronous, one rst cycle suffices):
  - state=IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0
  - mem_we=0, mem_addr=0, mem_wdata=0, reg_raddr=0
  - core_hold=1, core_start=0
- rst asserted mid-command: the command is abandoned, no mem_we is issued after the rst edge, and no response is produced.
- Latency, from the accept edge to the rsp_valid rise:
  - WR_MEM: 2 cycles
  - RD_MEM: 3 cycles
  - RD_REG: 2 cycles
  - RUN: 2 cycles
  - rejected command: 1 cycle
- cmd_ready=0 from the cycle after accept until the cycle after the response handshake.
- Back-to-back throughput: one WR every 3 cycles with rsp_ready held high.
- rsp_valid never drops without rsp_ready. rsp_data and rsp_err do not change while rsp_valid=1 and rsp_ready=0.
- core_start is high for exactly one cycle per accepted RUN.

## Test plan
- Load program: WR_MEM addr 0..8 with 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 -> nine mem_we pulses at the matching addresses, each response rsp_err=0, core_hold=1 throughout.
- Readback: RD_MEM addr 5 -> rsp_data=00222000 three cycles after accept. RD_MEM addr 1029 with AW=10 -> same data (wrap).
- Run and inspect: RUN -> one core_start pulse and core_hold=0. While running, RD_REG 1 -> rsp_err=1. After core_halted=1, RD_REG 1..5 -> 10, 20, 25, 30, 55.
- Backpressure: RD_REG 2 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, a second cmd_valid is not accepted.
- Reset mid-WR: assert rst in the WR cycle -> no further mem_we, no response, outputs at reset values, core_hold=1.
- RUN twice: a second RUN while core_halted=0 -> rsp_err=1 and no core_start pulse.

Source files
------------

// File: rtl/mips_dbg_loader.sv
// Debug/load responder: turns host word commands into memory writes/reads, register-file
// reads and a core release pulse. One command is outstanding at a time.
module mips_dbg_loader #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [4:0]    reg_raddr,
  input  logic [DW-1:0] reg_rdata,
  input  logic          core_halted,
  output logic          core_hold,
  output logic          core_start
);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdA,
    StRdD,
    StReg,
    StStart,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            hold_q, hold_d;
  logic            busy;

  // A released core that has not halted yet owns memory and the register file.
  assign busy = !hold_q && !core_halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      hold_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    hold_d     = hold_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d     = cmd_addr;
          data_d     = cmd_data;
          rsp_data_d = '0;
          rsp_err_d  = busy;
          if (busy) begin
            state_d = StResp;
          end else begin
            unique case (cmd_op)
              2'd0:    state_d = StWr;
              2'd1:    state_d = StRdA;
              2'd2:    state_d = StReg;
              default: state_d = StStart;
            endcase
          end
        end
      end
      StWr: begin
        hold_d  = 1'b1;
        state_d = StResp;
      end
      StRdA: state_d = StRdD;
      StRdD: begin
        rsp_data_d = mem_rdata;
        state_d    = StResp;
      end
      StReg: begin
        rsp_data_d = reg_rdata;
        state_d    = StResp;
      end
      StStart: begin
        hold_d  = 1'b0;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready  = (state_q == StIdle);
    rsp_valid  = (state_q == StResp);
    rsp_data   = rsp_data_q;
    rsp_err    = rsp_err_q;
    mem_we     = (state_q == StWr);
    mem_addr   = addr_q;
    mem_wdata  = data_q;
    reg_raddr  = addr_q[4:0];
    core_start = (state_q == StStart);
    // Hold drops in the START cycle itself, alongside the start pulse.
    core_hold  = hold_q && (state_q != StStart);
  end

endmodule

// File: tb/tb_mips_dbg_loader.sv
// Directed + randomized bench for mips_dbg_loader with behavioural memory, register file
// and a minimal core HALTED model.
module tb_mips_dbg_loader;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [4:0]    reg_raddr;
  logic [DW-1:0] reg_rdata;
  logic          core_halted, core_hold, core_start;

  mips_dbg_loader #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .core_halted(core_halted), .core_hold(core_hold), .core_start(core_start)
  );

  always #5 clk = ~clk;

  // Environment: registered-read memory, combinational register file, HALTED flag.
  logic [DW-1:0] tb_mem [1024];
  logic [DW-1:0] regs [32];
  logic          halted_q = 1'b0;
  logic          halt_req = 1'b0;
  int            cyc = 0, we_count = 0, start_count = 0;

  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    mem_rdata <= tb_mem[mem_addr];
    if (core_start) halted_q <= 1'b0;
    else if (halt_req) halted_q <= 1'b1;
    cyc <= cyc + 1;
    if (mem_we) we_count <= we_count + 1;
    if (core_start) start_count <= start_count + 1;
  end
  assign core_halted = halted_q;
  assign reg_rdata   = regs[reg_raddr];

  int tests = 0, fails = 0;
  int acc_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, output logic [DW-1:0] rd,
                        output logic er, output int lat);
    int n;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    acc_cyc = cyc;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    rd = rsp_data;
    er = rsp_err;
    @(negedge clk);
  endtask

  logic [DW-1:0] ref_mem [1024];
  logic [AW-1:0] written [$];
  logic [DW-1:0] prog [9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                              32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                              32'hfc000000};
  logic [DW-1:0] reg_exp [5] = '{32'd10, 32'd20, 32'd25, 32'd30, 32'd55};

  initial begin
    logic [DW-1:0] rd, d;
    logic          er;
    logic [AW-1:0] a;
    int            lat, we0, st0, prev_acc, wrap_addr, seen;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_reg_raddr", 32'(reg_raddr), 32'd0);
    check("rst_core_hold", 32'(core_hold), 32'd1);
    check("rst_core_start", 32'(core_start), 32'd0);

    // Program load, with back-to-back WR throughput.
    we0 = we_count;
    prev_acc = 0;
    for (int i = 0; i < 9; i++) begin
      do_cmd(2'd0, AW'(i), prog[i], rd, er, lat);
      ref_mem[i] = prog[i];
      check("load_lat", 32'(lat), 32'd2);
      check("load_err", 32'(er), 32'd0);
      check("load_data", rd, 32'd0);
      check("load_hold", 32'(core_hold), 32'd1);
      if (i > 0) check("wr_throughput", 32'(acc_cyc - prev_acc), 32'd3);
      prev_acc = acc_cyc;
    end
    check("load_we_pulses", 32'(we_count - we0), 32'd9);
    for (int i = 0; i < 9; i++) check("load_mem", tb_mem[i], ref_mem[i]);

    do_cmd(2'd1, AW'(5), '0, rd, er, lat);
    check("rd5_data", rd, 32'h00222000);
    check("rd5_lat", 32'(lat), 32'd3);
    wrap_addr = 1029;
    a = wrap_addr[AW-1:0];
    do_cmd(2'd1, a, '0, rd, er, lat);
    check("rd_wrap_data", rd, ref_mem[wrap_addr % 1024]);

    // Random writes/reads above the program area, scoreboarded against ref_mem.
    for (int i = 0; i < 16; i++) begin
      if (written.size() == 0 || $urandom_range(1, 0) == 1) begin
        a = AW'($urandom_range(1023, 16));
        d = $urandom;
        do_cmd(2'd0, a, d, rd, er, lat);
        ref_mem[a] = d;
        written.push_back(a);
        check("rnd_wr_err", 32'(er), 32'd0);
      end else begin
        a = written[$urandom_range(written.size() - 1, 0)];
        do_cmd(2'd1, a, '0, rd, er, lat);
        check("rnd_rd_data", rd, ref_mem[a]);
        check("rnd_rd_lat", 32'(lat), 32'd3);
      end
    end

    // Release the core.
    st0 = start_count;
    do_cmd(2'd3, '0, '0, rd, er, lat);
    check("run_err", 32'(er), 32'd0);
    check("run_lat", 32'(lat), 32'd2);
    check("run_start_pulses", 32'(start_count - st0), 32'd1);
    check("run_hold", 32'(core_hold), 32'd0);

    do_cmd(2'd2, AW'(1), '0, rd, er, lat);
    check("busy_reg_err", 32'(er), 32'd1);
    check("busy_reg_lat", 32'(lat), 32'd1);
    check("busy_reg_data", rd, 32'd0);
    we0 = we_count;
    do_cmd(2'd0, AW'(3), 32'hdeadbeef, rd, er, lat);
    check("busy_wr_err", 32'(er), 32'd1);
    check("busy_wr_no_we", 32'(we_count - we0), 32'd0);

    // Core halts with its results in r1..r5.
    for (int i = 0; i < 5; i++) regs[i + 1] = reg_exp[i];
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      a = {5'($urandom), 5'(i)};
      do_cmd(2'd2, a, '0, rd, er, lat);
      check("reg_data", rd, reg_exp[i - 1]);
      check("reg_err", 32'(er), 32'd0);
      check("reg_lat", 32'(lat), 32'd2);
    end

    // Backpressure with a competing command.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = AW'(2);
    @(posedge clk);
    @(negedge clk);
    cmd_op = 2'd0; cmd_addr = AW'(7); cmd_data = 32'h12345678;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    we0 = we_count;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", rsp_data, 32'd20);
      check("bp_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_done_ready", 32'(cmd_ready), 32'd1);
    check("bp_no_second", 32'(we_count - we0), 32'd0);

    // RUN twice.
    st0 = start_count;
    do_cmd(2'd3, '0, '0, rd, er, lat);
    check("run1_err", 32'(er), 32'd0);
    do_cmd(2'd3, '0, '0, rd, er, lat);
    check("run2_err", 32'(er), 32'd1);
    check("run2_pulses", 32'(start_count - st0), 32'd1);

    // Reset in the WR cycle.
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = AW'(100); cmd_data = 32'hcafef00d;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_wr_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    we0 = we_count;
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_hold", 32'(core_hold), 32'd1);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("mid_rst_no_rsp", 32'(seen), 32'd0);
    check("mid_rst_no_we", 32'(we_count - we0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
